// File: rtl/dvp_capture_ctrl.sv
// dvp_capture_ctrl
// ----------------
// Frame-level capture controller between the DVP pixel FIFO and the RGB
// concat / gray-scale path. It waits for a frame start (VSYNC-flagged byte),
// forwards the bytes of one frame while checking line/frame geometry, and then
// either re-arms for the next frame (continuous) or returns to IDLE (snapshot).
//
// Optional feature: define DVP_CAP_TIMEOUT_EN to add a TIMEOUT_W-bit watchdog
// that flags TIMEOUT and falls back to WAIT_FRM when no byte is accepted for
// 2^TIMEOUT_W-1 active, unstalled cycles. Without it err_status_o[4] is 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pxl_info_i/_vld_i    FIFO entry {VSYNC, HSYNC, data} and its valid
//   pxl_info_rdy_o       entry consumed on vld & rdy
//   pxl_data_o/_vld_o    registered forwarded byte and its valid
//   pxl_data_rdy_i       downstream ready
//   dcr_cam_start_i      start pulse (config and snapshot mode latched here)
//   dcr_cam_stop_i       stop pulse, returns to IDLE, wins over start
//   dcr_snapshot_i       1 = single frame, 0 = continuous
//   dcr_stall_i          level, freezes FIFO consumption and the watchdog
//   dcr_line_bytes_i     bytes per line
//   dcr_frame_lines_i    lines per frame
//   dcr_err_clr_i        clears the sticky error bits
//   busy_o               state != IDLE
//   frame_done_o         one-cycle pulse after the last byte of a frame
//   frame_cnt_o          completed frames since reset (wraps)
//   err_status_o         sticky {TIMEOUT, CFG, FRAME_SHORT, LINE_LONG, LINE_SHORT}
//   irq_err_o            OR of err_status_o
//   dbg_state            current FSM state (IDLE=0, WAIT_FRM=1, CAPTURE=2)
//
// Handshake: both sides use valid/ready. A transfer happens on a rising clock
// edge where valid and ready are both high; a source holds valid and data
// stable until that edge, and ready never depends on the source's valid.

module dvp_capture_ctrl #(
  parameter int DVP_DATA_W = 8,
  parameter int PXL_INFO_W = DVP_DATA_W + 2,
  parameter int LB_W       = 12,
  parameter int LN_W       = 11,
  parameter int FC_W       = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PXL_INFO_W-1:0] pxl_info_i,
  input  logic                  pxl_info_vld_i,
  output logic                  pxl_info_rdy_o,
  output logic [DVP_DATA_W-1:0] pxl_data_o,
  output logic                  pxl_data_vld_o,
  input  logic                  pxl_data_rdy_i,
  input  logic                  dcr_cam_start_i,
  input  logic                  dcr_cam_stop_i,
  input  logic                  dcr_snapshot_i,
  input  logic                  dcr_stall_i,
  input  logic [LB_W-1:0]       dcr_line_bytes_i,
  input  logic [LN_W-1:0]       dcr_frame_lines_i,
  input  logic                  dcr_err_clr_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [FC_W-1:0]       frame_cnt_o,
  output logic [4:0]            err_status_o,
  output logic                  irq_err_o,
  output logic [1:0]            dbg_state
);

  localparam int ERR_LINE_SHORT  = 0;
  localparam int ERR_LINE_LONG   = 1;
  localparam int ERR_FRAME_SHORT = 2;
  localparam int ERR_CFG         = 3;
  localparam int ERR_TIMEOUT     = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FRM = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [LB_W-1:0] line_bytes_q;
  logic [LN_W-1:0] frame_lines_q;
  logic            snapshot_q;
  logic [LB_W-1:0] byte_cnt, byte_cnt_n;
  logic [LN_W-1:0] line_cnt, line_cnt_n;

  logic            accept;
  logic            vsync, hsync;
  logic            fwd;
  logic            done;
  logic            latch_cfg;
  logic [4:0]      err_set;
  logic            timeout_set;

  assign vsync          = pxl_info_i[DVP_DATA_W+1];
  assign hsync          = pxl_info_i[DVP_DATA_W];
  assign busy_o         = (state != IDLE);
  assign dbg_state      = state;
  assign irq_err_o      = |err_status_o;
  // Consume only when active, not frozen, and the output register is free
  // or draining this cycle.
  assign pxl_info_rdy_o = busy_o & ~dcr_stall_i & (~pxl_data_vld_o | pxl_data_rdy_i);
  assign accept         = pxl_info_vld_i & pxl_info_rdy_o;

`ifdef DVP_CAP_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;

  assign timeout_set = busy_o & ~dcr_stall_i & ~accept & (&wd_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!busy_o || accept || timeout_set) begin
      wd_cnt <= '0;
    end else if (!dcr_stall_i) begin
      wd_cnt <= wd_cnt + TIMEOUT_W'(1);
    end
  end
`else
  // No watchdog in this build; the comparison keeps TIMEOUT_W referenced
  // and is constant 0 for any legal width.
  assign timeout_set = (TIMEOUT_W < 0);
`endif

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    line_cnt_n = line_cnt;
    fwd        = 1'b0;
    done       = 1'b0;
    latch_cfg  = 1'b0;
    err_set    = '0;

    case (state)
      IDLE: begin
        if (dcr_cam_start_i && !dcr_cam_stop_i) begin
          if (dcr_line_bytes_i == '0 || dcr_frame_lines_i == '0) begin
            err_set[ERR_CFG] = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            state_n   = WAIT_FRM;
          end
        end
      end

      WAIT_FRM: begin
        // Everything before a frame start is dropped.
        if (accept && vsync) begin
          fwd        = 1'b1;
          byte_cnt_n = LB_W'(1);
          line_cnt_n = '0;
          state_n    = CAPTURE;
        end
      end

      CAPTURE: begin
        if (accept) begin
          if (vsync) begin
            // New frame before the old one completed: restart on it.
            err_set[ERR_FRAME_SHORT] = 1'b1;
            fwd        = 1'b1;
            byte_cnt_n = LB_W'(1);
            line_cnt_n = '0;
          end else if (hsync) begin
            if (byte_cnt == line_bytes_q) begin
              fwd        = 1'b1;
              byte_cnt_n = LB_W'(1);
              line_cnt_n = line_cnt + LN_W'(1);
            end else begin
              err_set[ERR_LINE_SHORT] = 1'b1;
              state_n = WAIT_FRM;
            end
          end else if (byte_cnt == line_bytes_q) begin
            err_set[ERR_LINE_LONG] = 1'b1;
            state_n = WAIT_FRM;
          end else begin
            fwd        = 1'b1;
            byte_cnt_n = byte_cnt + LB_W'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Completion is judged on the counters after this byte is counted, which
    // also covers a one-byte frame whose VSYNC byte is the whole frame.
    if (fwd && line_cnt_n == frame_lines_q - LN_W'(1) && byte_cnt_n == line_bytes_q) begin
      done    = 1'b1;
      state_n = snapshot_q ? IDLE : WAIT_FRM;
    end

    if (timeout_set) begin
      err_set[ERR_TIMEOUT] = 1'b1;
      state_n = WAIT_FRM;
    end

    // Stop drops any byte accepted in the same cycle and its framing checks.
    if (dcr_cam_stop_i) begin
      state_n      = IDLE;
      fwd          = 1'b0;
      done         = 1'b0;
      err_set[2:0] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      line_cnt       <= '0;
      line_bytes_q   <= '0;
      frame_lines_q  <= '0;
      snapshot_q     <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_cnt_o    <= '0;
      err_status_o   <= '0;
      pxl_data_o     <= '0;
      pxl_data_vld_o <= 1'b0;
    end else begin
      state        <= state_n;
      byte_cnt     <= byte_cnt_n;
      line_cnt     <= line_cnt_n;
      frame_done_o <= done;
      if (done) begin
        frame_cnt_o <= frame_cnt_o + FC_W'(1);
      end
      if (latch_cfg) begin
        line_bytes_q  <= dcr_line_bytes_i;
        frame_lines_q <= dcr_frame_lines_i;
        snapshot_q    <= dcr_snapshot_i;
      end
      // A bit being set in the same cycle as a clear stays set.
      err_status_o <= (dcr_err_clr_i ? 5'b0 : err_status_o) | err_set;
      if (fwd) begin
        pxl_data_o     <= pxl_info_i[DVP_DATA_W-1:0];
        pxl_data_vld_o <= 1'b1;
      end else if (pxl_data_rdy_i) begin
        pxl_data_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
`timescale 1ns/1ps
module tb_dvp_capture_ctrl;

  localparam int DW   = 8;
  localparam int PW   = DW + 2;
  localparam int LB_W = 12;
  localparam int LN_W = 11;
  localparam int FC_W = 16;
`ifdef DVP_CAP_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 20;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0]   pxl_info_i = '0;
  logic            pxl_info_vld_i = 1'b0;
  logic            pxl_info_rdy_o;
  logic [DW-1:0]   pxl_data_o;
  logic            pxl_data_vld_o;
  logic            pxl_data_rdy_i = 1'b0;
  logic            dcr_cam_start_i = 1'b0;
  logic            dcr_cam_stop_i = 1'b0;
  logic            dcr_snapshot_i = 1'b0;
  logic            dcr_stall_i = 1'b0;
  logic [LB_W-1:0] dcr_line_bytes_i = '0;
  logic [LN_W-1:0] dcr_frame_lines_i = '0;
  logic            dcr_err_clr_i = 1'b0;
  logic            busy_o;
  logic            frame_done_o;
  logic [FC_W-1:0] frame_cnt_o;
  logic [4:0]      err_status_o;
  logic            irq_err_o;
  logic [1:0]      dbg_state;

  dvp_capture_ctrl #(
    .DVP_DATA_W(DW), .PXL_INFO_W(PW), .LB_W(LB_W), .LN_W(LN_W),
    .FC_W(FC_W), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pxl_info_i(pxl_info_i), .pxl_info_vld_i(pxl_info_vld_i), .pxl_info_rdy_o(pxl_info_rdy_o),
    .pxl_data_o(pxl_data_o), .pxl_data_vld_o(pxl_data_vld_o), .pxl_data_rdy_i(pxl_data_rdy_i),
    .dcr_cam_start_i(dcr_cam_start_i), .dcr_cam_stop_i(dcr_cam_stop_i),
    .dcr_snapshot_i(dcr_snapshot_i), .dcr_stall_i(dcr_stall_i),
    .dcr_line_bytes_i(dcr_line_bytes_i), .dcr_frame_lines_i(dcr_frame_lines_i),
    .dcr_err_clr_i(dcr_err_clr_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o), .err_status_o(err_status_o), .irq_err_o(irq_err_o),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] fifo_q[$];   // source FIFO contents
  logic [DW-1:0] exp_q[$];    // bytes expected downstream, in order
  int vld_pct = 100;
  int rdy_pct = 100;

  // Reference model: a frame is tracked as the number of bytes forwarded so
  // far (m_pos, 0 = waiting for a frame start).
  bit            m_busy = 0;
  bit            m_snap = 0;
  int            m_pos  = 0;
  int            m_lb   = 0;
  int            m_fl   = 0;
  logic [4:0]    m_err  = '0;
  logic [FC_W-1:0] m_cnt = '0;
  bit            m_done = 0;
  bit            m_vld  = 0;
  logic [DW-1:0] m_data = '0;
  int            m_wd   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit acc, input logic [PW-1:0] px);
    bit fwd;
    bit nb;
    bit v;
    bit h;
    logic [4:0] set;
    fwd = 0; set = '0; nb = m_busy;
    v = px[DW+1]; h = px[DW];
    m_done = 0;
    if (!m_busy) begin
      if (dcr_cam_start_i && !dcr_cam_stop_i) begin
        if (dcr_line_bytes_i == 0 || dcr_frame_lines_i == 0) set[3] = 1;
        else begin
          nb = 1; m_pos = 0;
          m_lb = int'(dcr_line_bytes_i); m_fl = int'(dcr_frame_lines_i);
          m_snap = dcr_snapshot_i;
        end
      end
    end else if (acc && !dcr_cam_stop_i) begin
      if (m_pos == 0) begin
        if (v) begin fwd = 1; m_pos = 1; end
      end else if (v) begin
        set[2] = 1; fwd = 1; m_pos = 1;
      end else if (m_pos % m_lb == 0) begin
        // a full line is in: only a line start may follow
        if (h) begin fwd = 1; m_pos++; end
        else begin set[1] = 1; m_pos = 0; end
      end else begin
        if (h) begin set[0] = 1; m_pos = 0; end
        else begin fwd = 1; m_pos++; end
      end
      if (fwd && m_pos == m_lb * m_fl) begin
        m_done = 1; m_cnt++; m_pos = 0;
        if (m_snap) nb = 0;
      end
    end
`ifdef DVP_CAP_TIMEOUT_EN
    if (!m_busy || acc) m_wd = 0;
    else if (!dcr_stall_i) begin
      if (m_wd == (1 << TW) - 1) begin set[4] = 1; m_wd = 0; m_pos = 0; end
      else m_wd++;
    end
`endif
    if (dcr_cam_stop_i) nb = 0;
    m_busy = nb;
    m_err = (dcr_err_clr_i ? 5'b0 : m_err) | set;
    if (fwd) begin
      m_vld = 1; m_data = px[DW-1:0];
      exp_q.push_back(px[DW-1:0]);
    end else if (pxl_data_rdy_i) m_vld = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered at a falling edge; control pulses set by the caller last one cycle.
  task automatic cycle();
    bit exp_rdy, acc_d, acc_m, hs_out;
    logic [DW-1:0] out_byte;
    pxl_info_i     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    pxl_info_vld_i = (fifo_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
    pxl_data_rdy_i = ($urandom_range(0, 99) < rdy_pct);
    #1;
    exp_rdy = m_busy && !dcr_stall_i && (!m_vld || pxl_data_rdy_i);
    check("info_rdy", pxl_info_rdy_o, exp_rdy);
    acc_d    = pxl_info_vld_i && pxl_info_rdy_o;
    acc_m    = pxl_info_vld_i && exp_rdy;
    hs_out   = pxl_data_vld_o && pxl_data_rdy_i;
    out_byte = pxl_data_o;
    model_step(acc_m, pxl_info_i);
    @(posedge clk);
    #1;
    if (acc_d) void'(fifo_q.pop_front());
    if (hs_out) begin
      if (exp_q.size() == 0) check("drain_extra", 1, 0);
      else check("drain_data", out_byte, exp_q.pop_front());
    end
    check("busy", busy_o, m_busy);
    check("state", dbg_state, !m_busy ? 0 : (m_pos == 0 ? 1 : 2));
    check("frame_done", frame_done_o, m_done);
    check("frame_cnt", frame_cnt_o, m_cnt);
    check("err_status", err_status_o, m_err);
    check("irq_err", irq_err_o, |m_err);
    check("data_vld", pxl_data_vld_o, m_vld);
    if (m_vld) check("data_hold", pxl_data_o, m_data);
    dcr_cam_start_i = 0;
    dcr_cam_stop_i  = 0;
    dcr_err_clr_i   = 0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (((fifo_q.size() > 0 && m_busy) || m_vld) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_done", ((fifo_q.size() > 0 && m_busy) || m_vld), 0);
  endtask

  task automatic start(input int lb, input int fl, input bit snap);
    dcr_line_bytes_i  = LB_W'(lb);
    dcr_frame_lines_i = LN_W'(fl);
    dcr_snapshot_i    = snap;
    dcr_cam_start_i   = 1;
    cycle();
  endtask

  // kind: 0 clean, 1 early HSYNC, 2 extra byte in a line, 3 truncated frame
  task automatic push_frame(input int lb, input int fl, input int kind);
    int cl, len, total, pushed;
    logic [PW-1:0] e;
    cl = $urandom_range(0, fl - 1);
    total = (lb * fl > 1) ? $urandom_range(1, lb * fl - 1) : 1;
    pushed = 0;
    for (int l = 0; l < fl; l++) begin
      len = lb;
      if (kind == 1 && l == cl && lb > 1) len = $urandom_range(1, lb - 1);
      if (kind == 2 && l == cl) len = lb + 1;
      for (int b = 0; b < len; b++) begin
        if (kind == 3 && pushed >= total) return;
        e[DW-1:0] = DW'($urandom);
        e[DW+1]   = (l == 0 && b == 0);
        e[DW]     = (l > 0 && b == 0);
        fifo_q.push_back(e);
        pushed++;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int sz;
    // reset
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_vld", pxl_data_vld_o, 0);
    check("rst_rdy", pxl_info_rdy_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_err", err_status_o, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1;

    // 1: two-line frame, continuous
    start(4, 2, 0);
    for (int i = 0; i < 8; i++)
      fifo_q.push_back({(i == 0), (i == 4), 8'(8'h10 + i)});
    drain(100);
    check("t1_frame_cnt", frame_cnt_o, 1);
    check("t1_state_wait", dbg_state, 1);
    check("t1_exp_empty", exp_q.size(), 0);

    // 2: snapshot, second frame stays in the FIFO
    dcr_cam_stop_i = 1; cycle();
    start(4, 2, 1);
    push_frame(4, 2, 0);
    push_frame(4, 2, 0);
    run(40);
    check("t2_fifo_held", fifo_q.size(), 8);
    check("t2_busy", busy_o, 0);
    check("t2_rdy", pxl_info_rdy_o, 0);
    check("t2_frame_cnt", frame_cnt_o, 2);
    fifo_q.delete();

    // 3: short line, then a good frame, then clear
    start(4, 2, 0);
    fifo_q.push_back({2'b10, 8'hA0});
    fifo_q.push_back({2'b00, 8'hA1});
    fifo_q.push_back({2'b00, 8'hA2});
    fifo_q.push_back({2'b01, 8'hA3});
    for (int i = 0; i < 3; i++) fifo_q.push_back({2'b00, 8'(8'hB0 + i)});
    push_frame(4, 2, 0);
    drain(200);
    check("t3_err", err_status_o[3:0], 4'b0001);
    check("t3_irq", irq_err_o, 1);
    check("t3_frame_cnt", frame_cnt_o, 3);
    dcr_err_clr_i = 1; cycle();
    check("t3_err_clr", err_status_o[3:0], 0);

    // 4: downstream back-pressure, then stall
    push_frame(4, 2, 0);
    run(3);
    rdy_pct = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_bp_rdy", pxl_info_rdy_o, 0);
    end
    rdy_pct = 100;
    dcr_stall_i = 1;
    sz = fifo_q.size();
    run(5);
    check("t4_stall_fifo", fifo_q.size(), sz);
    dcr_stall_i = 0;
    drain(100);
    check("t4_frame_cnt", frame_cnt_o, 4);

    // 5: zero config, then stop with a held output byte
    dcr_cam_stop_i = 1; cycle();
    start(0, 2, 0);
    check("t5_cfg_err", err_status_o[3:0], 4'b1000);
    check("t5_idle", busy_o, 0);
    dcr_err_clr_i = 1; cycle();
    start(4, 2, 0);
    push_frame(4, 2, 0);
    run(3);
    rdy_pct = 0;
    run(2);
    dcr_cam_stop_i = 1; cycle();
    check("t5_stop_idle", busy_o, 0);
    check("t5_held", pxl_data_vld_o, 1);
    rdy_pct = 100;
    run(3);
    check("t5_drained", pxl_data_vld_o, 0);
    check("t5_exp_empty", exp_q.size(), 0);
    fifo_q.delete();

`ifdef DVP_CAP_TIMEOUT_EN
    // watchdog: frame start, then nothing
    start(4, 2, 0);
    fifo_q.push_back({2'b10, 8'h55});
    run(2);
    run(30);
    check("wd_timeout", err_status_o[4], 1);
    check("wd_state", dbg_state, 1);
    dcr_cam_stop_i = 1; cycle();
`endif

    // random rounds
    for (int r = 0; r < 10; r++) begin
      int k, lb, fl;
      dcr_cam_stop_i = 1; cycle();
      fifo_q.delete();
      lb = $urandom_range(1, 5);
      fl = $urandom_range(1, 3);
      vld_pct = $urandom_range(50, 100);
      rdy_pct = $urandom_range(40, 100);
      start(lb, fl, $urandom_range(0, 1));
      for (int f = 0; f < 3; f++)
        push_frame(lb, fl, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      k = 0;
      while (((fifo_q.size() > 0 && m_busy) || m_vld) && k < 3000) begin
        dcr_stall_i = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 39) == 0) dcr_err_clr_i = 1;
        if ($urandom_range(0, 99) == 0) dcr_cam_start_i = 1;
        if ($urandom_range(0, 299) == 0) dcr_cam_stop_i = 1;
        cycle();
        k++;
      end
      dcr_stall_i = 0;
      check("rnd_progress", ((fifo_q.size() > 0 && m_busy) || m_vld), 0);
    end

    rdy_pct = 100;
    dcr_cam_stop_i = 1; cycle();
    fifo_q.delete();
    drain(50);
    check("final_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
